// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - producer and UART-side signal bundle for uart_tx_queue
//
// Purpose: groups the enqueue port, queue status and the UART DIN/OE/RDY
// handshake so they travel as one port.
// Signals:
//   WDATA, WE          byte and strobe from the producer
//   FULL, EMPTY, LEVEL queue status (LEVEL is $clog2(Depth)+1 bits)
//   OVF                sticky overflow flag (constant 0 unless enabled)
//   DIN, OE            byte and one-cycle transmit strobe to the UART
//   RDY                UART transmitter idle
// Modports: master = producer/UART side, slave = the queue.
interface uart_tx_queue_if #(
  parameter int Depth = 16
) ();
  localparam int LW = $clog2(Depth) + 1;

  logic [7:0]    WDATA;
  logic          WE;
  logic          FULL;
  logic          EMPTY;
  logic [LW-1:0] LEVEL;
  logic          OVF;
  logic [7:0]    DIN;
  logic          OE;
  logic          RDY;

  modport master (
    output WDATA, WE, RDY,
    input  FULL, EMPTY, LEVEL, OVF, DIN, OE
  );

  modport slave (
    input  WDATA, WE, RDY,
    output FULL, EMPTY, LEVEL, OVF, DIN, OE
  );
endinterface

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO with paced transmit sequencer feeding a UART
//
// Purpose: buffers bytes pushed at clock rate and hands them one at a time to
// the UART transmitter, waiting for RDY and leaving a gap cycle after each OE.
// Ports:
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset
//   q      uart_tx_queue_if.slave: WDATA/WE in, FULL/EMPTY/LEVEL/OVF out,
//          DIN/OE out to the UART, RDY in from the UART
// Parameter Depth: FIFO entries, power of two, >= 2.
// Macro UART_TX_QUEUE_OVF_EN: when defined, OVF latches any write attempted
// while FULL; when undefined, OVF is constant 0.
module uart_tx_queue #(
  parameter int Depth = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  uart_tx_queue_if.slave  q
);
  localparam int PW = $clog2(Depth);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [Depth];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [LW-1:0] level;
  logic [7:0]    din_q;
  logic          oe_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Status comes only from the registered occupancy, so a pop in the same
  // cycle never frees a slot for a write while full.
  assign full  = (level == LW'(Depth));
  assign empty = (level == '0);
  assign push  = q.WE && !full;
  assign pop   = (state == IDLE) && !empty && q.RDY;

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr] <= q.WDATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sequencer. GAP exists because the UART only drops RDY the cycle after it
  // samples OE; looking at RDY then would launch a second byte too early.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      oe_q  <= 1'b0;
      din_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          oe_q <= 1'b0;
          if (pop) begin
            din_q <= mem[rptr];
            oe_q  <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          oe_q  <= 1'b0;
          state <= GAP;
        end
        GAP: begin
          oe_q  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          oe_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_QUEUE_OVF_EN
  logic ovf_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
    end else if (q.WE && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign q.OVF = ovf_q;
`else
  assign q.OVF = 1'b0;
`endif

  assign q.FULL  = full;
  assign q.EMPTY = empty;
  assign q.LEVEL = level;
  assign q.DIN   = din_q;
  assign q.OE    = oe_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue
module tb_uart_tx_queue;
  logic CLK;
  logic RST_N;

  uart_tx_queue_if #(.Depth(16)) bus ();

  uart_tx_queue #(.Depth(16)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .q     (bus)
  );

`ifdef UART_TX_QUEUE_OVF_EN
  localparam int OvfExp = 1;
`else
  localparam int OvfExp = 0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       rdy;
    logic       oe;
    logic [7:0] din;
    int         level;
    logic       empty;
    logic       full;
  } vec_t;

  vec_t tbl[13];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cool = 0;
  logic prev_oe = 1'b0;
  logic [7:0] sent[$];
  int sent_t[$];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One clock cycle: drive inputs just after the rising edge, sample outputs
  // at the falling edge. rdy_mode 0 = RDY low, 1 = RDY high, 2 = UART model
  // (RDY low for 10 cycles after every OE).
  task automatic tick(input logic we, input logic [7:0] wd, input int rdy_mode);
    @(posedge CLK);
    #1;
    cyc++;
    bus.WE    = we;
    bus.WDATA = wd;
    if (rdy_mode == 2) begin
      if (cool > 0) begin
        bus.RDY = 1'b0;
        cool--;
      end else begin
        bus.RDY = 1'b1;
      end
    end else begin
      bus.RDY = (rdy_mode == 1);
    end
    @(negedge CLK);
    if (bus.OE) begin
      if (prev_oe) chk("oe_back_to_back", 1, 0);
      sent.push_back(bus.DIN);
      sent_t.push_back(cyc);
      cool = 10;
    end
    prev_oe = bus.OE;
  endtask

  task automatic drain_until(input int n, input int budget);
    int k;
    k = 0;
    while (sent.size() < n && k < budget) begin
      tick(1'b0, 8'h00, 2);
      k++;
    end
    chk("drain_timeout", int'(sent.size() >= n), 1);
  endtask

  task automatic clear_sent();
    sent.delete();
    sent_t.delete();
  endtask

  initial begin
    //        we    wd     rdy   oe    din    lvl empty full
    tbl[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h41, 0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h41, 1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h41, 2, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h41, 3, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h41, 4, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 5, 1'b0, 1'b0};

    RST_N     = 1'b1;
    bus.WE    = 1'b0;
    bus.WDATA = 8'h00;
    bus.RDY   = 1'b0;
    #3 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_empty", int'(bus.EMPTY), 1);
    chk("rst_full",  int'(bus.FULL),  0);
    chk("rst_level", int'(bus.LEVEL), 0);
    chk("rst_oe",    int'(bus.OE),    0);
    chk("rst_din",   int'(bus.DIN),   0);
    chk("rst_ovf",   int'(bus.OVF),   0);
    RST_N = 1'b1;

    // Single byte, then load five bytes under backpressure.
    clear_sent();
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].we, tbl[i].wd, tbl[i].rdy ? 1 : 0);
      chk($sformatf("vec%0d_oe", i),    int'(bus.OE),    int'(tbl[i].oe));
      chk($sformatf("vec%0d_din", i),   int'(bus.DIN),   int'(tbl[i].din));
      chk($sformatf("vec%0d_level", i), int'(bus.LEVEL), tbl[i].level);
      chk($sformatf("vec%0d_empty", i), int'(bus.EMPTY), int'(tbl[i].empty));
      chk($sformatf("vec%0d_full", i),  int'(bus.FULL),  int'(tbl[i].full));
    end
    chk("single_count", sent.size(), 1);
    if (sent.size() > 0) chk("single_byte", int'(sent[0]), 'h41);

    // Drain under the UART model.
    clear_sent();
    cool = 0;
    drain_until(5, 100);
    repeat (15) tick(1'b0, 8'h00, 2);
    chk("bp_count", sent.size(), 5);
    for (int i = 0; i < 5 && i < sent.size(); i++)
      chk($sformatf("bp_byte%0d", i), int'(sent[i]), i + 1);
    for (int i = 1; i < 5 && i < sent.size(); i++)
      chk($sformatf("bp_gap%0d", i), int'(sent_t[i] - sent_t[i-1] >= 11), 1);

    // Fill to 16, attempt a 17th write.
    clear_sent();
    for (int i = 0; i < 17; i++) tick(1'b1, 8'(i), 0);
    chk("fill_full_at_17th",  int'(bus.FULL), 1);
    chk("fill_ovf_not_early", int'(bus.OVF),  0);
    tick(1'b0, 8'h00, 0);
    chk("fill_full",  int'(bus.FULL),  1);
    chk("fill_level", int'(bus.LEVEL), 16);
    chk("fill_empty", int'(bus.EMPTY), 0);
    chk("fill_ovf",   int'(bus.OVF),   OvfExp);
    cool = 0;
    drain_until(16, 250);
    repeat (20) tick(1'b0, 8'h00, 2);
    chk("fill_count", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      chk($sformatf("fill_byte%0d", i), int'(sent[i]), i);
    chk("fill_ovf_sticky", int'(bus.OVF), OvfExp);

    // Twenty more bytes in two batches so the pointers wrap again.
    clear_sent();
    for (int i = 0; i < 12; i++) tick(1'b1, 8'(8'h20 + i), 0);
    cool = 0;
    drain_until(12, 200);
    for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'h2C + i), 0);
    cool = 0;
    drain_until(20, 150);
    repeat (15) tick(1'b0, 8'h00, 2);
    chk("wrap_count", sent.size(), 20);
    for (int i = 0; i < 20 && i < sent.size(); i++)
      chk($sformatf("wrap_byte%0d", i), int'(sent[i]), 'h20 + i);

    // Write while full in the very cycle that pops.
    clear_sent();
    for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'h50 + i), 0);
    tick(1'b0, 8'h00, 0);
    chk("sim_pre_level", int'(bus.LEVEL), 16);
    tick(1'b1, 8'hAA, 1);
    tick(1'b0, 8'h00, 0);
    chk("sim_level", int'(bus.LEVEL), 15);
    chk("sim_oe",    int'(bus.OE),    1);
    chk("sim_din",   int'(bus.DIN),   'h50);
    drain_until(16, 250);
    repeat (20) tick(1'b0, 8'h00, 2);
    chk("sim_count", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      chk($sformatf("sim_byte%0d", i), int'(sent[i]), 'h50 + i);

    // Asynchronous reset in the middle of SEND with three bytes left.
    clear_sent();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h61 + i), 0);
    tick(1'b0, 8'h00, 1);
    tick(1'b0, 8'h00, 0);
    chk("mid_oe_before",    int'(bus.OE),    1);
    chk("mid_level_before", int'(bus.LEVEL), 3);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_oe",    int'(bus.OE),    0);
    chk("mid_din",   int'(bus.DIN),   0);
    chk("mid_level", int'(bus.LEVEL), 0);
    chk("mid_empty", int'(bus.EMPTY), 1);
    chk("mid_full",  int'(bus.FULL),  0);
    chk("mid_ovf",   int'(bus.OVF),   0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    clear_sent();
    prev_oe = 1'b0;
    repeat (20) tick(1'b0, 8'h00, 1);
    chk("post_rst_no_oe", sent.size(), 0);
    chk("post_rst_level", int'(bus.LEVEL), 0);
    tick(1'b1, 8'h77, 1);
    repeat (5) tick(1'b0, 8'h00, 1);
    chk("post_rst_count", sent.size(), 1);
    if (sent.size() > 0) chk("post_rst_byte", int'(sent[0]), 'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
